pwm_duty_decoder: RTL and testbench
===================================

Name: pwm_duty_decoder

Overview:
- Receive-side counterpart of the LED flasher's PWM drive: samples a single asynchronous PWM/LED line and measures its period and high time in clock cycles.
- Produces a B-bit-scaled duty value on the same scale the flasher uses for brightness.
- Used for loopback self-test of the flasher outputs and for reading externally PWM-driven inputs.
- Detects a stuck line (0 % or 100 %) via counter saturation.

Parameters:
- CNT_W, 16: width of the period and high-time counters; saturation value is 2^CNT_W-1.
- B, 5: duty resolution; duty = floor(high*2^B/period), range 0..2^B.
- SYNC_STAGES, 2: input synchroniser depth, minimum 2.

Ports:
- Clk  in  1  system clock.
- sys_rst  in  1  reset.
- pwm_in  in  1  asynchronous PWM line.
- period_cnt  out  CNT_W  last complete period, in cycles.
- high_cnt  out  CNT_W  high cycles within that period.
- duty  out  B+1  scaled duty; 2^B means 100 %.
- valid  out  1  one-cycle pulse when the outputs above update.
- stuck  out  1  line has not toggled for 2^CNT_W-1 cycles.
- stuck_level  out  1  line level while stuck is high.
- overrun  out  1  sticky; a period was dropped because the divider was busy.

Interface (already decided): one clock, Clk; reset sys_rst is synchronous and active-high.

Behaviour:

Reset:
- While sys_rst=1 at a Clk edge, every output and internal register goes to 0.
- The FSM returns to WAIT_EDGE.
- Asserting reset mid-divide discards the division; no valid is produced for it.

Input path:
- pwm_in passes through SYNC_STAGES flops to give lvl.
- lvl_d is lvl delayed by one cycle.
- rise = lvl & ~lvl_d. With SYNC_STAGES=2, rise is seen 3 edges after a pin rise.

Counters:
- On rise: per_ctr <= 1; hi_ctr <= 1.
- Otherwise: per_ctr increments every cycle; hi_ctr increments when lvl=1.
- Both saturate at 2^CNT_W-1 and never wrap.

FSM states: WAIT_EDGE, MEASURE, DIVIDE, STUCK.
- WAIT_EDGE: on rise, go to MEASURE. No valid, because the first period is incomplete.
- MEASURE, on rise:
  - Snapshot per_ctr to period_cnt and hi_ctr to high_cnt (the values before the counters reload).
  - Start the divider; go to DIVIDE.
- DIVIDE: B+1 restoring iterations, one quotient bit per cycle, MSB first.
  - On completion: write duty, pulse valid, return to MEASURE.
  - valid fires exactly B+2 cycles after the rise cycle.
  - A rise during DIVIDE reloads the counters, is not snapshotted, and sets overrun. overrun clears only on reset.
- Any state except WAIT_EDGE, when per_ctr reaches saturation:
  - Go to STUCK; stuck=1; stuck_level=lvl.
  - duty = lvl ? 2^B : 0; period_cnt = high_cnt = 2^CNT_W-1.
  - Pulse valid once, on entry only.
  - Saturation takes priority over a divider in flight, which is abandoned.
- STUCK: on rise, clear stuck and go to MEASURE. The next rise produces a valid measurement.
- WAIT_EDGE with the line never toggling: after saturation, enter STUCK exactly as above.

Arithmetic:
- Dividend = high_cnt concatenated with B zeros; divisor = period_cnt.
- high_cnt <= period_cnt always holds, so the quotient fits in B+1 bits.
- period_cnt is never 0 on a division.
- Quotient is truncated (floor).

Decomposition:
- Shared package holds the state encoding (2-bit enum), the DIV_LAT = B+2 constant, and the saturation constant function.
- One sub-module, duty_divider: sequential restoring divider.
  - Ports: Clk, sys_rst, start, dividend (CNT_W+B), divisor (CNT_W), abort, quotient (B+1), done (pulse).
- The synchroniser and edge detect stay inline.

Test Plan (all with B=5):
1. Reset, then a steady PWM with pin period 32 cycles and high 8 cycles. The first rise gives no valid. The second rise gives period_cnt=32, high_cnt=8, duty=8, with valid exactly 7 cycles after rise. Repeats every 32 cycles.
2. Sweep high time with period 32: high = 0(toggle-free excluded), 1, 16, 31 -> duty = 1, 16, 31. Period 33 with high 11 -> duty=10 (floor).
3. CNT_W=8, pwm_in held 1 after one rise -> at per_ctr=255: stuck=1, stuck_level=1, duty=32, a single valid. Then a period-32 PWM resumes -> stuck clears on the rise; the next rise gives a normal valid.
4. CNT_W=8, pwm_in held 0 from reset -> stuck=1, stuck_level=0, duty=0 after 255 cycles. Exactly one valid.
5. Pin period 4 (shorter than DIV_LAT=7) -> overrun=1 stays set; each completed division reports period_cnt=4, high_cnt matching the high time.
6. Assert sys_rst for 1 cycle 3 cycles into DIVIDE -> no valid; all outputs 0; the FSM requires two fresh rises before the next valid.

Source files
------------

// File: rtl/pwm_duty_decoder_pkg.sv
// pwm_duty_decoder_pkg
//   Shared definitions for the PWM duty decoder: FSM state encoding, divider
//   latency and the counter saturation value.
package pwm_duty_decoder_pkg;

  typedef enum logic [1:0] {
    StWaitEdge = 2'd0,
    StMeasure  = 2'd1,
    StDivide   = 2'd2,
    StStuck    = 2'd3
  } state_e;

  // Cycles from the rise cycle to the valid pulse for a duty resolution of b bits.
  function automatic int unsigned div_lat(input int unsigned b);
    return b + 32'd2;
  endfunction

  // Largest value of a w-bit counter.
  function automatic int unsigned sat_val(input int unsigned w);
    return (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  localparam int unsigned DefaultB      = 5;
  localparam int unsigned DefaultDivLat = div_lat(DefaultB);

endpackage

// File: rtl/pwm_duty_decoder_duty_divider.sv
// pwm_duty_decoder_duty_divider
//   Sequential restoring divider producing a (B+1)-bit quotient, MSB first, one
//   bit per cycle. The caller guarantees dividend < divisor * 2^(B+1), so only
//   the top CNT_W-1 dividend bits seed the remainder.
// Ports:
//   Clk, sys_rst   clock, synchronous active-high reset
//   start          load dividend/divisor and begin (ignored while abort)
//   dividend       CNT_W+B bits
//   divisor        CNT_W bits, never 0
//   abort          drop the division in flight
//   quotient       B+1 bits, valid while done is high
//   done           one-cycle pulse on the final iteration
module pwm_duty_decoder_duty_divider import pwm_duty_decoder_pkg::*; #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned B     = 5
) (
  input  logic               Clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [CNT_W+B-1:0] dividend,
  input  logic [CNT_W-1:0]   divisor,
  input  logic               abort,
  output logic [B:0]         quotient,
  output logic               done
);

  localparam int unsigned Iters = div_lat(B) - 1;
  localparam int unsigned CntW  = $clog2(Iters + 1);

  logic             r_busy;
  logic [CntW-1:0]  r_cnt;
  logic [CNT_W-1:0] r_rem;
  logic [B:0]       r_bits;
  logic [B-1:0]     r_q;
  logic [CNT_W-1:0] r_dvs;

  logic [CNT_W:0]   w_trial;
  logic [CNT_W:0]   w_diff;
  logic             w_ge;
  logic [CNT_W-1:0] w_next_rem;

  // trial < 2*divisor, so the sign of trial-divisor lands in the top bit.
  always_comb begin
    w_trial    = {r_rem, r_bits[B]};
    w_diff     = w_trial - {1'b0, r_dvs};
    w_ge       = ~w_diff[CNT_W];
    w_next_rem = w_ge ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
  end

  assign done     = r_busy && (r_cnt == CntW'(1));
  assign quotient = {r_q, w_ge};

  always_ff @(posedge Clk) begin
    if (sys_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_bits <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CntW'(Iters);
      r_rem  <= {1'b0, dividend[CNT_W+B-1:B+1]};
      r_bits <= dividend[B:0];
      r_q    <= '0;
      r_dvs  <= divisor;
    end else if (r_busy) begin
      r_rem  <= w_next_rem;
      r_bits <= {r_bits[B-1:0], 1'b0};
      r_q    <= B'({r_q, w_ge});
      r_cnt  <= r_cnt - CntW'(1);
      if (r_cnt == CntW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
//   Measures period and high time of an asynchronous PWM line and converts
//   them to a duty value floor(high*2^B/period) on a 0..2^B scale. Flags a
//   line that stops toggling via counter saturation.
// Ports:
//   Clk, sys_rst   clock, synchronous active-high reset
//   pwm_in         asynchronous PWM line
//   period_cnt     last complete period in cycles (CNT_W)
//   high_cnt       high cycles within that period (CNT_W)
//   duty           scaled duty, 2^B = 100 % (B+1)
//   valid          one-cycle pulse when the outputs above update
//   stuck          line has not toggled for 2^CNT_W-1 cycles
//   stuck_level    line level while stuck
//   overrun        sticky: a rise arrived while the divider was busy
module pwm_duty_decoder import pwm_duty_decoder_pkg::*; #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned B           = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             sys_rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [B:0]       duty,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] Sat      = CNT_W'(sat_val(CNT_W));
  localparam logic [B:0]       DutyFull = {1'b1, {B{1'b0}}};

  // Input synchroniser and rising-edge detect.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lvl_d;
  logic                   w_lvl;
  logic                   w_rise;

  assign w_lvl  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_lvl & ~r_lvl_d;

  always_ff @(posedge Clk) begin
    if (sys_rst) begin
      r_sync  <= '0;
      r_lvl_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_lvl_d <= w_lvl;
    end
  end

  // Period and high-time counters; both stick at Sat rather than wrap.
  logic [CNT_W-1:0] r_per_ctr;
  logic [CNT_W-1:0] r_hi_ctr;
  logic             w_sat;

  assign w_sat = (r_per_ctr == Sat);

  always_ff @(posedge Clk) begin
    if (sys_rst) begin
      r_per_ctr <= '0;
      r_hi_ctr  <= '0;
    end else if (w_rise) begin
      r_per_ctr <= CNT_W'(1);
      r_hi_ctr  <= CNT_W'(1);
    end else begin
      if (!w_sat) begin
        r_per_ctr <= r_per_ctr + CNT_W'(1);
      end
      if (w_lvl && (r_hi_ctr != Sat)) begin
        r_hi_ctr <= r_hi_ctr + CNT_W'(1);
      end
    end
  end

  // FSM and registered outputs.
  state_e           r_state;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [B:0]       r_duty;
  logic             r_valid;
  logic             r_stuck;
  logic             r_stuck_lvl;
  logic             r_overrun;

  logic             w_go_stuck;
  logic             w_start;
  logic             w_abort;
  logic [B:0]       w_quotient;
  logic             w_div_done;

  // Saturation wins over everything except an already-stuck line.
  assign w_go_stuck = w_sat && (r_state != StStuck);
  assign w_start    = (r_state == StMeasure) && w_rise && !w_go_stuck;
  assign w_abort    = (r_state == StDivide) && w_go_stuck;

  pwm_duty_decoder_duty_divider #(
    .CNT_W (CNT_W),
    .B     (B)
  ) u_duty_divider (
    .Clk      (Clk),
    .sys_rst  (sys_rst),
    .start    (w_start),
    .dividend ({r_hi_ctr, {B{1'b0}}}),
    .divisor  (r_per_ctr),
    .abort    (w_abort),
    .quotient (w_quotient),
    .done     (w_div_done)
  );

  always_ff @(posedge Clk) begin
    if (sys_rst) begin
      r_state     <= StWaitEdge;
      r_period    <= '0;
      r_high      <= '0;
      r_duty      <= '0;
      r_valid     <= 1'b0;
      r_stuck     <= 1'b0;
      r_stuck_lvl <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_go_stuck) begin
        r_state     <= StStuck;
        r_stuck     <= 1'b1;
        r_stuck_lvl <= w_lvl;
        r_duty      <= w_lvl ? DutyFull : '0;
        r_period    <= Sat;
        r_high      <= Sat;
        r_valid     <= 1'b1;
      end else begin
        unique case (r_state)
          StWaitEdge: begin
            // First period after reset is incomplete, so it is not reported.
            if (w_rise) r_state <= StMeasure;
          end
          StMeasure: begin
            if (w_rise) begin
              r_period <= r_per_ctr;
              r_high   <= r_hi_ctr;
              r_state  <= StDivide;
            end
          end
          StDivide: begin
            if (w_rise) r_overrun <= 1'b1;
            if (w_div_done) begin
              r_duty  <= w_quotient;
              r_valid <= 1'b1;
              r_state <= StMeasure;
            end
          end
          StStuck: begin
            if (w_rise) begin
              r_stuck     <= 1'b0;
              r_stuck_lvl <= 1'b0;
              r_state     <= StMeasure;
            end
          end
          default: r_state <= StWaitEdge;
        endcase
      end
    end
  end

  assign period_cnt  = r_period;
  assign high_cnt    = r_high;
  assign duty        = r_duty;
  assign valid       = r_valid;
  assign stuck       = r_stuck;
  assign stuck_level = r_stuck_lvl;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder
//   Directed bench for pwm_duty_decoder with CNT_W=8, B=5. Expected reports are
//   queued when the pin rises and matched against each valid pulse, including
//   the cycle it arrives on.
module tb_pwm_duty_decoder;

  localparam int unsigned CntW = 8;
  localparam int unsigned BW   = 5;
  localparam int          SatV = 255;
  localparam int          Full = 32;
  // Pin rise driven after posedge n gives valid sampled after posedge n+9.
  localparam int          Lat  = 9;

  logic            Clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic            pwm_in = 1'b0;
  logic [CntW-1:0] period_cnt;
  logic [CntW-1:0] high_cnt;
  logic [BW:0]     duty;
  logic            valid;
  logic            stuck;
  logic            stuck_level;
  logic            overrun;

  pwm_duty_decoder #(
    .CNT_W       (CntW),
    .B           (BW),
    .SYNC_STAGES (2)
  ) dut (
    .Clk         (Clk),
    .sys_rst     (sys_rst),
    .pwm_in      (pwm_in),
    .period_cnt  (period_cnt),
    .high_cnt    (high_cnt),
    .duty        (duty),
    .valid       (valid),
    .stuck       (stuck),
    .stuck_level (stuck_level),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int t;
    int per;
    int hi;
    int dty;
    int stk;
    int lvl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Bench model of which rises get measured.
  int m_meas    = 0;
  int m_free_at = 0;
  int m_ovr     = 0;
  int prev_h    = 0;
  int prev_l    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int t, input int per, input int hi, input int dty,
                          input int stk, input int lvl);
    exp_t x;
    x.t   = t;
    x.per = per;
    x.hi  = hi;
    x.dty = dty;
    x.stk = stk;
    x.lvl = lvl;
    sb.push_back(x);
  endtask

  // One PWM period starting with a rise at the current negedge.
  task automatic pwm_period(input int h, input int l);
    if (m_meas != 0 && cyc >= m_free_at) begin
      push_exp(cyc + Lat, prev_h + prev_l, prev_h, (prev_h * Full) / (prev_h + prev_l), 0, 0);
      m_free_at = cyc + 7;
    end else if (m_meas != 0) begin
      m_ovr = 1;
    end
    m_meas = 1;
    pwm_in = 1'b1;
    repeat (h) @(negedge Clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge Clk);
    prev_h = h;
    prev_l = l;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, period_cnt, 0);
    chk({tag, "_high"}, high_cnt, 0);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_stuck"}, stuck, 0);
    chk({tag, "_stuck_level"}, stuck_level, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    repeat (12) @(negedge Clk);
    chk("queue_drained", sb.size(), 0);
    sys_rst = 1'b1;
    repeat (3) @(negedge Clk);
    check_zero("reset");
    sys_rst   = 1'b0;
    m_meas    = 0;
    m_free_at = 0;
    m_ovr     = 0;
  endtask

  // Scoreboard side: every valid must match the head of the queue, on time.
  always @(negedge Clk) begin
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("valid_unexpected_qdepth", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("valid_cycle", cyc, e.t);
        chk("period_cnt", period_cnt, e.per);
        chk("high_cnt", high_cnt, e.hi);
        chk("duty", duty, e.dty);
        chk("stuck_at_valid", stuck, e.stk);
        chk("stuck_level_at_valid", stuck_level, e.lvl);
      end
    end else if (sb.size() != 0 && cyc > sb[0].t) begin
      chk("valid_missing_cycle", cyc, sb[0].t);
      void'(sb.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;

  initial begin
    // Reset state, then steady 32/8 PWM; first rise is not reported.
    do_reset();
    repeat (4) @(negedge Clk);
    pwm_period(8, 24);
    pwm_period(8, 24);
    pwm_period(8, 24);
    pwm_period(8, 24);

    // High-time sweep at period 32, then 33/11 for floor rounding.
    pwm_period(1, 31);
    pwm_period(16, 16);
    pwm_period(31, 1);
    pwm_period(11, 22);
    pwm_period(8, 24);
    chk("overrun_clear", overrun, m_ovr);

    // Period 4 is shorter than the divider latency: every other rise is dropped.
    for (int i = 0; i < 12; i++) pwm_period(2, 2);
    repeat (12) @(negedge Clk);
    chk("overrun_set", overrun, m_ovr);
    chk("overrun_model", m_ovr, 1);

    // Reset three cycles into a division.
    do_reset();
    pwm_period(8, 24);
    pwm_in = 1'b1;
    repeat (2) @(negedge Clk);
    pwm_in = 1'b0;
    repeat (3) @(negedge Clk);
    sys_rst = 1'b1;
    @(negedge Clk);
    check_zero("mid_divide_reset");
    sys_rst   = 1'b0;
    m_meas    = 0;
    m_free_at = 0;
    m_ovr     = 0;
    repeat (12) @(negedge Clk);
    chk("no_valid_after_abort_qdepth", sb.size(), 0);
    pwm_period(8, 24);
    pwm_period(8, 24);
    pwm_period(8, 24);

    // Line held high after one rise: stuck high, single valid.
    do_reset();
    pwm_in = 1'b1;
    n = cyc;
    push_exp(n + 258, SatV, SatV, Full, 1, 1);
    m_meas = 0;
    repeat (300) @(negedge Clk);
    chk("stuck_high", stuck, 1);
    chk("stuck_high_level", stuck_level, 1);
    pwm_in = 1'b0;
    repeat (10) @(negedge Clk);
    pwm_period(8, 24);
    chk("stuck_cleared", stuck, 0);
    chk("stuck_level_cleared", stuck_level, 0);
    pwm_period(8, 24);
    pwm_period(8, 24);

    // Line held low from reset: stuck low, single valid.
    do_reset();
    n = cyc;
    push_exp(n + 256, SatV, SatV, 0, 1, 0);
    repeat (300) @(negedge Clk);
    chk("stuck_low", stuck, 1);
    chk("stuck_low_level", stuck_level, 0);

    repeat (4) @(negedge Clk);
    chk("final_queue_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
